i_term_gen: RTL

//  Parametrised integral-term unit for the balance/steer PID path. Integrates saturated

---
 rtl/pid_pkg.sv | 13 +
 rtl/i_term_sat_add.sv | 31 +++
 rtl/i_term_gen.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pid_pkg.sv
// Shared types and constants for the PID datapath blocks.
package pid_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } i_state_t;

    localparam int unsigned SAT_FREEZE = 0;
    localparam int unsigned SAT_CLAMP  = 1;

endpackage

// File: rtl/i_term_sat_add.sv
// Signed accumulator adder with overflow detection and freeze/clamp result selection.
module i_term_sat_add
    import pid_pkg::*;
#(
    parameter int unsigned INT_W    = 15,
    parameter int unsigned SAT_MODE = SAT_CLAMP
) (
    input  logic [INT_W-1:0] acc,
    input  logic [INT_W-1:0] addend,
    output logic [INT_W-1:0] res_c,
    output logic             ov_c
);

    logic [INT_W-1:0] sum;

    // Overflow only possible when both operands share a sign and the sum flips it.
    always_comb begin
        sum   = acc + addend;
        ov_c  = (addend[INT_W-1] == acc[INT_W-1]) && (sum[INT_W-1] != acc[INT_W-1]);
        res_c = sum;
        if (ov_c) begin
            if (SAT_MODE == SAT_CLAMP) begin
                res_c = addend[INT_W-1] ? {1'b1, {(INT_W-1){1'b0}}}
                                        : {1'b0, {(INT_W-1){1'b1}}};
            end else begin
                res_c = acc;
            end
        end
    end

endmodule

// File: rtl/i_term_gen.sv
// Integral term generator: decimated saturating integrator with anti-windup hold,
// sync clear and geometric drain when motion stops.
module i_term_gen
    import pid_pkg::*;
#(
    parameter int unsigned ERR_W       = 10,
    parameter int unsigned INT_W       = 15,
    parameter int unsigned OUT_W       = 9,
    parameter int unsigned DECIM       = 1,
    parameter int unsigned SAT_MODE    = SAT_CLAMP,
    parameter int unsigned DRAIN_SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             moving,
    input  logic             err_vld,
    input  logic [ERR_W-1:0] error_sat,
    input  logic             hold,
    input  logic             clr,
    output logic [OUT_W-1:0] I_term,
    output logic             I_vld,
    output logic             sat,
    output logic             drain_busy
);

    localparam int unsigned      CNT_W    = $clog2(DECIM + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    i_state_t                state_q, state_d;
    logic signed [INT_W-1:0] integ_q, integ_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sat_d, vld_d;

    logic [INT_W-1:0]        ext;
    logic [INT_W-1:0]        add_res;
    logic                    add_ov;
    logic signed [INT_W-1:0] drain_step;
    logic                    drain_end;

    assign ext        = {{(INT_W-ERR_W){error_sat[ERR_W-1]}}, error_sat};
    assign drain_step = integ_q >>> DRAIN_SHIFT;
    // Stop draining once the step rounds to nothing in either sign.
    assign drain_end  = (drain_step == '0) || (drain_step == '1);
    assign I_term     = integ_q[INT_W-1 -: OUT_W];

    i_term_sat_add #(
        .INT_W    (INT_W),
        .SAT_MODE (SAT_MODE)
    ) u_sat_add (
        .acc    (integ_q),
        .addend (ext),
        .res_c  (add_res),
        .ov_c   (add_ov)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        integ_d = integ_q;
        cnt_d   = cnt_q;
        sat_d   = sat;
        vld_d   = 1'b0;
        if (clr) begin
            integ_d = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
            state_d = moving ? RUN : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    integ_d = '0;
                    if (moving) state_d = RUN;
                end
                RUN: begin
                    if (!moving) begin
                        cnt_d = '0;
                        if ((integ_q != '0) && (DRAIN_SHIFT > 0)) begin
                            state_d = DRAIN;
                        end else begin
                            integ_d = '0;
                            sat_d   = 1'b0;
                            state_d = IDLE;
                        end
                    end else if (err_vld && !hold) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            integ_d = add_res;
                            sat_d   = add_ov;
                            vld_d   = 1'b1;
                        end else begin
                            cnt_d = CNT_W'(cnt_q + 1'b1);
                        end
                    end
                end
                DRAIN: begin
                    if (moving) begin
                        state_d = RUN;
                    end else if (drain_end) begin
                        integ_d = '0;
                        sat_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        integ_d = integ_q - drain_step;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            integ_q    <= '0;
            cnt_q      <= '0;
            sat        <= 1'b0;
            I_vld      <= 1'b0;
            drain_busy <= 1'b0;
        end else begin
            state_q    <= state_d;
            integ_q    <= integ_d;
            cnt_q      <= cnt_d;
            sat        <= sat_d;
            I_vld      <= vld_d;
            drain_busy <= (state_d == DRAIN);
        end
    end

endmodule
